// File: rtl/stock_dir_pckg.sv
// Shared ITCH 5.0 constants for the message parser: type codes, body lengths,
// field byte offsets within the body, and the framing FSM state type.
package stock_dir_pckg;

  typedef enum logic [1:0] {
    LEN_HI = 2'd0,
    LEN_LO = 2'd1,
    BODY   = 2'd2
  } parse_state_t;

  localparam logic [7:0] TYPE_ADD      = 8'h41;  // 'A'
  localparam logic [7:0] TYPE_ADD_MPID = 8'h46;  // 'F'
  localparam logic [7:0] TYPE_DELETE   = 8'h44;  // 'D'
  localparam logic [7:0] TYPE_EXEC     = 8'h45;  // 'E'
  localparam logic [7:0] TYPE_CANCEL   = 8'h58;  // 'X'

  localparam logic [15:0] LEN_ADD      = 16'd36;
  localparam logic [15:0] LEN_ADD_MPID = 16'd40;
  localparam logic [15:0] LEN_DELETE   = 16'd19;
  localparam logic [15:0] LEN_EXEC     = 16'd31;
  localparam logic [15:0] LEN_CANCEL   = 16'd23;

  localparam logic [15:0] OFF_TYPE    = 16'd0;
  localparam logic [15:0] OFF_LOC_LO  = 16'd1;
  localparam logic [15:0] OFF_LOC_HI  = 16'd2;
  localparam logic [15:0] OFF_REF_LO  = 16'd11;
  localparam logic [15:0] OFF_REF_HI  = 16'd18;
  localparam logic [15:0] OFF_BS      = 16'd19;
  localparam logic [15:0] OFF_SH_LO   = 16'd20;
  localparam logic [15:0] OFF_SH_HI   = 16'd23;
  localparam logic [15:0] OFF_PX_LO   = 16'd32;
  localparam logic [15:0] OFF_PX_HI   = 16'd35;
  localparam logic [15:0] OFF_XSH_LO  = 16'd19;
  localparam logic [15:0] OFF_XSH_HI  = 16'd22;

  // Zero means "type not supported".
  function automatic logic [15:0] expected_len(input logic [7:0] msg_type);
    case (msg_type)
      TYPE_ADD:      return LEN_ADD;
      TYPE_ADD_MPID: return LEN_ADD_MPID;
      TYPE_DELETE:   return LEN_DELETE;
      TYPE_EXEC:     return LEN_EXEC;
      TYPE_CANCEL:   return LEN_CANCEL;
      default:       return 16'd0;
    endcase
  endfunction

  function automatic logic in_field(input logic [15:0] idx, input logic [15:0] lo,
                                    input logic [15:0] hi);
    return (idx >= lo) && (idx <= hi);
  endfunction

endpackage

// File: rtl/itch_msg_parser.sv
// Length-prefixed ITCH 5.0 parser decoding A/F/D/E/X; results one cycle after the last byte.
// No backpressure: one byte per in_valid cycle. Optional locate filter: STOCK_FILTER_EN.
import stock_dir_pckg::*;

module itch_msg_parser #(
  parameter logic [15:0] TARGET_LOCATE = 16'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        new_instr,
  output logic [7:0]  message_type,
  output logic [7:0]  buy_sell_indicator,
  output logic [63:0] order_id,
  output logic [31:0] quantity,
  output logic [31:0] price,
  output logic [15:0] stock_locate,
  output logic        len_err
);

  parse_state_t state, state_nxt;
  logic [7:0]   len_hi, len_hi_nxt;
  logic [15:0]  msg_len, msg_len_nxt;
  logic [15:0]  cnt, cnt_nxt;

  // Field shift registers; shifted only while the counter is inside the field.
  logic [7:0]   type_sr, type_nxt;
  logic [15:0]  loc_sr, loc_nxt;
  logic [63:0]  ref_sr, ref_nxt;
  logic [7:0]   bs_sr, bs_nxt;
  logic [31:0]  sh_sr, sh_nxt;
  logic [31:0]  px_sr, px_nxt;
  logic [31:0]  xsh_sr, xsh_nxt;

  logic         last;
  logic [15:0]  exp_len;
  logic         known, len_ok, is_af, is_ex, filter_pass, emit, err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= LEN_HI;
      len_hi  <= '0;
      msg_len <= '0;
      cnt     <= '0;
      type_sr <= '0;
      loc_sr  <= '0;
      ref_sr  <= '0;
      bs_sr   <= '0;
      sh_sr   <= '0;
      px_sr   <= '0;
      xsh_sr  <= '0;
    end else begin
      state   <= state_nxt;
      len_hi  <= len_hi_nxt;
      msg_len <= msg_len_nxt;
      cnt     <= cnt_nxt;
      type_sr <= type_nxt;
      loc_sr  <= loc_nxt;
      ref_sr  <= ref_nxt;
      bs_sr   <= bs_nxt;
      sh_sr   <= sh_nxt;
      px_sr   <= px_nxt;
      xsh_sr  <= xsh_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    len_hi_nxt  = len_hi;
    msg_len_nxt = msg_len;
    cnt_nxt     = cnt;
    type_nxt    = type_sr;
    loc_nxt     = loc_sr;
    ref_nxt     = ref_sr;
    bs_nxt      = bs_sr;
    sh_nxt      = sh_sr;
    px_nxt      = px_sr;
    xsh_nxt     = xsh_sr;
    last        = 1'b0;
    if (in_valid) begin
      case (state)
        LEN_HI: begin
          len_hi_nxt = in_byte;
          state_nxt  = LEN_LO;
        end
        LEN_LO: begin
          msg_len_nxt = {len_hi, in_byte};
          cnt_nxt     = '0;
          state_nxt   = ({len_hi, in_byte} != 16'd0) ? BODY : LEN_HI;
        end
        BODY: begin
          if (cnt == OFF_TYPE)                       type_nxt = in_byte;
          if (in_field(cnt, OFF_LOC_LO, OFF_LOC_HI)) loc_nxt  = {loc_sr[7:0], in_byte};
          if (in_field(cnt, OFF_REF_LO, OFF_REF_HI)) ref_nxt  = {ref_sr[55:0], in_byte};
          if (cnt == OFF_BS)                         bs_nxt   = in_byte;
          if (in_field(cnt, OFF_SH_LO, OFF_SH_HI))   sh_nxt   = {sh_sr[23:0], in_byte};
          if (in_field(cnt, OFF_PX_LO, OFF_PX_HI))   px_nxt   = {px_sr[23:0], in_byte};
          if (in_field(cnt, OFF_XSH_LO, OFF_XSH_HI)) xsh_nxt  = {xsh_sr[23:0], in_byte};
          if (cnt == msg_len - 16'd1) begin
            last      = 1'b1;
            cnt_nxt   = '0;
            state_nxt = LEN_HI;
          end else begin
            cnt_nxt = cnt + 16'd1;
          end
        end
        default: state_nxt = LEN_HI;
      endcase
    end
  end

  // Decode uses the *_nxt views so a field ending on the final byte is complete.
  always_comb begin
    exp_len = expected_len(type_nxt);
    known   = (exp_len != 16'd0);
    len_ok  = (msg_len == exp_len);
    is_af   = (type_nxt == TYPE_ADD) || (type_nxt == TYPE_ADD_MPID);
    is_ex   = (type_nxt == TYPE_EXEC) || (type_nxt == TYPE_CANCEL);
  end

`ifdef STOCK_FILTER_EN
  assign filter_pass = (loc_nxt == TARGET_LOCATE);
`else
  logic unused_target;
  assign unused_target = &{1'b0, TARGET_LOCATE};
  assign filter_pass   = 1'b1;
`endif

  assign emit = last && known && len_ok && filter_pass;
  assign err  = last && known && !len_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      new_instr          <= 1'b0;
      len_err            <= 1'b0;
      message_type       <= '0;
      buy_sell_indicator <= '0;
      order_id           <= '0;
      quantity           <= '0;
      price              <= '0;
      stock_locate       <= '0;
    end else begin
      new_instr <= emit;
      len_err   <= err;
      if (emit) begin
        message_type       <= type_nxt;
        buy_sell_indicator <= is_af ? bs_nxt : 8'h00;
        order_id           <= ref_nxt;
        quantity           <= is_af ? sh_nxt : (is_ex ? xsh_nxt : 32'd0);
        price              <= is_af ? px_nxt : 32'd0;
        stock_locate       <= loc_nxt;
      end
    end
  end

endmodule
